id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the segmented RISC-V core.
- Consumes the stall (enable) and bubble (clr) requests from the load-use hazard logic, plus the taken-branch flush from the execute stage.
- Captures decoded operands and control into the execute stage, holds them, or replaces them with a bubble.
- Marks every stage slot with a valid bit and zeroes all side-effect controls on bubbles, so a bubble never re-triggers a hazard.

Parameters:
- XLEN, 32, data/PC width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  1 = advance decode into execute; 0 = stall request from the hazard logic.
- clr  in  1  1 = load a bubble into execute.
- ex_flush  in  1  taken branch/jump resolved in execute; load a bubble.
- de_valid  in  1  decode slot holds a real instruction.
- de_pc  in  XLEN  instruction PC.
- de_rs1_data  in  XLEN  register file read port 1.
- de_rs2_data  in  XLEN  register file read port 2.
- de_imm  in  XLEN  decoded immediate.
- de_rs1, de_rs2, de_rd  in  5 each  register indices.
- de_alu_op  in  4  ALU operation.
- de_alu_src  in  1  ALU operand B select (1 = imm).
- de_rf_we  in  1  register write enable.
- de_dmrd  in  1  data-memory read.
- de_dmwr  in  1  data-memory write.
- de_branch  in  1  branch instruction.
- de_jump  in  1  jump instruction.
- de_wb_sel  in  2  write-back source select.
- ex_*  out  (same widths)  registered copies of every de_* input above, including ex_valid.
- bubble_cnt  out  CNT_W  bubbles inserted (perf).
- stall_cnt  out  CNT_W  cycles held (perf).

Behaviour:
- Reset (asynchronous, rst=1): every ex_* output = 0, so ex_valid=0 and ex_rd=0; bubble_cnt = 0; stall_cnt = 0.
- Update priority at each rising clk edge, with rst low:
  1. clr | ex_flush → BUBBLE.
  2. enable = 1 → LOAD.
  3. Otherwise → HOLD.
- BUBBLE:
  - ex_valid, ex_rf_we, ex_dmrd, ex_dmwr, ex_branch, ex_jump = 0.
  - ex_rd, ex_rs1, ex_rs2 = 0; ex_alu_op, ex_wb_sel = 0.
  - Data fields (pc, rs*_data, imm) = 0.
  - Applies regardless of enable: clr=1 with enable=0 (load-use) and clr=1 with enable=1 are both bubbles.
- LOAD:
  - All ex_* take the de_* values; latency 1 cycle.
  - If de_valid=0, side-effect controls (rf_we, dmrd, dmwr, branch, jump) are forced to 0, so an invalid slot is always a clean bubble.
- HOLD: all ex_* keep their values.
- Load-use sequence with enable=0, clr=1 for one cycle:
  - Next cycle ex_dmrd = 0 and ex_rd = 0.
  - The hazard logic therefore deasserts, and the stalled instruction enters execute on the following edge.
- Counters: bubble_cnt +1 on each BUBBLE edge; stall_cnt +1 on each HOLD edge. Both saturate at 2^CNT_W-1 (no wrap).
- A simultaneous clr and ex_flush counts as one bubble.
- Reset mid-operation clears state immediately, without waiting for a clock edge. The first edge after rst falls follows the normal priority.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: bubble_cnt and stall_cnt are implemented as described.
- Undefined: no counter flops; both ports are tied to constant 0; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1, ex_rd=7 → all outputs 0 before the next clk edge; counters 0.
- Load: enable=1, clr=0, de_valid=1, de_pc=0x100, de_rd=5, de_rf_we=1 → next edge ex_pc=0x100, ex_rd=5, ex_rf_we=1, ex_valid=1.
- Load-use: ex holds a load to rd=3 (ex_dmrd=1); drive enable=0, clr=1 for 1 cycle → ex_valid=0, ex_dmrd=0, ex_rd=0, bubble_cnt=1. Next edge with enable=1 → the held decode instruction (rs1=3) appears in ex.
- Hold: enable=0, clr=0 for 3 cycles, with de_* changing each cycle → ex_* unchanged; stall_cnt=3.
- Flush: ex_flush=1 and clr=1 together, with de_dmwr=1 → ex_dmwr=0, ex_valid=0, bubble_cnt +1 (not +2).
- Invalid load: enable=1, de_valid=0, de_dmwr=1, de_rf_we=1 → ex_dmwr=0, ex_rf_we=0, ex_valid=0.
- Saturation (CNT_W=4): 20 consecutive bubbles → bubble_cnt=15.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// Decode/execute boundary bundle: stage controls, decode-side payload and execute-side copies.
// The slave modport is the pipeline register; the master modport drives decode and observes execute.
interface id_ex_reg_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic            enable;
   logic            clr;
   logic            ex_flush;

   logic            de_valid;
   logic [XLEN-1:0] de_pc;
   logic [XLEN-1:0] de_rs1_data;
   logic [XLEN-1:0] de_rs2_data;
   logic [XLEN-1:0] de_imm;
   logic [4:0]      de_rs1;
   logic [4:0]      de_rs2;
   logic [4:0]      de_rd;
   logic [3:0]      de_alu_op;
   logic            de_alu_src;
   logic            de_rf_we;
   logic            de_dmrd;
   logic            de_dmwr;
   logic            de_branch;
   logic            de_jump;
   logic [1:0]      de_wb_sel;

   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [3:0]      ex_alu_op;
   logic            ex_alu_src;
   logic            ex_rf_we;
   logic            ex_dmrd;
   logic            ex_dmwr;
   logic            ex_branch;
   logic            ex_jump;
   logic [1:0]      ex_wb_sel;

   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output enable, clr, ex_flush,
      output de_valid, de_pc, de_rs1_data, de_rs2_data, de_imm, de_rs1, de_rs2, de_rd,
      output de_alu_op, de_alu_src, de_rf_we, de_dmrd, de_dmwr, de_branch, de_jump, de_wb_sel,
      input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
      input  ex_alu_op, ex_alu_src, ex_rf_we, ex_dmrd, ex_dmwr, ex_branch, ex_jump, ex_wb_sel,
      input  bubble_cnt, stall_cnt
   );

   modport slave (
      input  enable, clr, ex_flush,
      input  de_valid, de_pc, de_rs1_data, de_rs2_data, de_imm, de_rs1, de_rs2, de_rd,
      input  de_alu_op, de_alu_src, de_rf_we, de_dmrd, de_dmwr, de_branch, de_jump, de_wb_sel,
      output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
      output ex_alu_op, ex_alu_src, ex_rf_we, ex_dmrd, ex_dmwr, ex_branch, ex_jump, ex_wb_sel,
      output bubble_cnt, stall_cnt
   );
endinterface

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: load, hold or bubble the execute slot.
// Define ID_EX_PERF_EN to build the saturating bubble/stall counters; otherwise they read 0.
module id_ex_reg #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic        clk,
   input logic        rst,
   id_ex_reg_if.slave bus
);
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            alu_src;
      logic            rf_we;
      logic            dmrd;
      logic            dmwr;
      logic            branch;
      logic            jump;
      logic [1:0]      wb_sel;
   } ex_slot_t;

   ex_slot_t ex_q;
   ex_slot_t ex_d;
   logic     bubble_c;

   // Flush and clear collapse into one bubble and override enable.
   assign bubble_c = bus.clr | bus.ex_flush;

   always_comb begin
      ex_d = ex_q;
      if (bubble_c) begin
         ex_d = '0;
      end else if (bus.enable) begin
         ex_d.valid    = bus.de_valid;
         ex_d.pc       = bus.de_pc;
         ex_d.rs1_data = bus.de_rs1_data;
         ex_d.rs2_data = bus.de_rs2_data;
         ex_d.imm      = bus.de_imm;
         ex_d.rs1      = bus.de_rs1;
         ex_d.rs2      = bus.de_rs2;
         ex_d.rd       = bus.de_rd;
         ex_d.alu_op   = bus.de_alu_op;
         ex_d.alu_src  = bus.de_alu_src;
         ex_d.wb_sel   = bus.de_wb_sel;
         // An invalid decode slot must never carry side effects into execute.
         ex_d.rf_we    = bus.de_rf_we  & bus.de_valid;
         ex_d.dmrd     = bus.de_dmrd   & bus.de_valid;
         ex_d.dmwr     = bus.de_dmwr   & bus.de_valid;
         ex_d.branch   = bus.de_branch & bus.de_valid;
         ex_d.jump     = bus.de_jump   & bus.de_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.ex_valid    = ex_q.valid;
   assign bus.ex_pc       = ex_q.pc;
   assign bus.ex_rs1_data = ex_q.rs1_data;
   assign bus.ex_rs2_data = ex_q.rs2_data;
   assign bus.ex_imm      = ex_q.imm;
   assign bus.ex_rs1      = ex_q.rs1;
   assign bus.ex_rs2      = ex_q.rs2;
   assign bus.ex_rd       = ex_q.rd;
   assign bus.ex_alu_op   = ex_q.alu_op;
   assign bus.ex_alu_src  = ex_q.alu_src;
   assign bus.ex_rf_we    = ex_q.rf_we;
   assign bus.ex_dmrd     = ex_q.dmrd;
   assign bus.ex_dmwr     = ex_q.dmwr;
   assign bus.ex_branch   = ex_q.branch;
   assign bus.ex_jump     = ex_q.jump;
   assign bus.ex_wb_sel   = ex_q.wb_sel;

`ifdef ID_EX_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             hold_c;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   assign hold_c = ~bubble_c & ~bus.enable;

   // Saturating counters: stick at all-ones rather than wrap.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (bubble_c && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
      if (hold_c && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.bubble_cnt = bubble_cnt_q;
   assign bus.stall_cnt  = stall_cnt_q;
`else
   assign bus.bubble_cnt = CNT_W'(0);
   assign bus.stall_cnt  = CNT_W'(0);
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a slot-level reference model (CNT_W=4 for saturation).
// Counter expectations follow ID_EX_PERF_EN: modelled values when defined, 0 otherwise.
module tb_id_ex_reg;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = 15;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            alu_src;
      logic            rf_we;
      logic            dmrd;
      logic            dmwr;
      logic            branch;
      logic            jump;
      logic [1:0]      wb_sel;
   } instr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_ex_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
   id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int     n_tests = 0;
   int     n_fail  = 0;
   instr_t de;
   logic   en, cl, fl;
   instr_t m_ex;
   int     m_bubble, m_stall;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive();
      bus.enable      = en;
      bus.clr         = cl;
      bus.ex_flush    = fl;
      bus.de_valid    = de.valid;
      bus.de_pc       = de.pc;
      bus.de_rs1_data = de.rs1_data;
      bus.de_rs2_data = de.rs2_data;
      bus.de_imm      = de.imm;
      bus.de_rs1      = de.rs1;
      bus.de_rs2      = de.rs2;
      bus.de_rd       = de.rd;
      bus.de_alu_op   = de.alu_op;
      bus.de_alu_src  = de.alu_src;
      bus.de_rf_we    = de.rf_we;
      bus.de_dmrd     = de.dmrd;
      bus.de_dmwr     = de.dmwr;
      bus.de_branch   = de.branch;
      bus.de_jump     = de.jump;
      bus.de_wb_sel   = de.wb_sel;
   endtask

   function automatic instr_t rand_instr();
      instr_t r;
      r.valid    = 1'($urandom);
      r.pc       = $urandom;
      r.rs1_data = $urandom;
      r.rs2_data = $urandom;
      r.imm      = $urandom;
      r.rs1      = 5'($urandom);
      r.rs2      = 5'($urandom);
      r.rd       = 5'($urandom);
      r.alu_op   = 4'($urandom);
      r.alu_src  = 1'($urandom);
      r.rf_we    = 1'($urandom);
      r.dmrd     = 1'($urandom);
      r.dmwr     = 1'($urandom);
      r.branch   = 1'($urandom);
      r.jump     = 1'($urandom);
      r.wb_sel   = 2'($urandom);
      return r;
   endfunction

   // Reference: what instruction occupies execute after one clock edge.
   task automatic model_edge();
      if (rst) begin
         m_ex = '0; m_bubble = 0; m_stall = 0;
      end else if (cl || fl) begin
         m_ex = '0;
         m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
      end else if (en) begin
         m_ex = de;
         if (!de.valid) begin
            m_ex.rf_we = 0; m_ex.dmrd = 0; m_ex.dmwr = 0; m_ex.branch = 0; m_ex.jump = 0;
         end
      end else begin
         m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
   endtask

   task automatic check_all();
      check("ex_valid",    64'(bus.ex_valid),    64'(m_ex.valid));
      check("ex_pc",       64'(bus.ex_pc),       64'(m_ex.pc));
      check("ex_rs1_data", 64'(bus.ex_rs1_data), 64'(m_ex.rs1_data));
      check("ex_rs2_data", 64'(bus.ex_rs2_data), 64'(m_ex.rs2_data));
      check("ex_imm",      64'(bus.ex_imm),      64'(m_ex.imm));
      check("ex_rs1",      64'(bus.ex_rs1),      64'(m_ex.rs1));
      check("ex_rs2",      64'(bus.ex_rs2),      64'(m_ex.rs2));
      check("ex_rd",       64'(bus.ex_rd),       64'(m_ex.rd));
      check("ex_alu_op",   64'(bus.ex_alu_op),   64'(m_ex.alu_op));
      check("ex_alu_src",  64'(bus.ex_alu_src),  64'(m_ex.alu_src));
      check("ex_rf_we",    64'(bus.ex_rf_we),    64'(m_ex.rf_we));
      check("ex_dmrd",     64'(bus.ex_dmrd),     64'(m_ex.dmrd));
      check("ex_dmwr",     64'(bus.ex_dmwr),     64'(m_ex.dmwr));
      check("ex_branch",   64'(bus.ex_branch),   64'(m_ex.branch));
      check("ex_jump",     64'(bus.ex_jump),     64'(m_ex.jump));
      check("ex_wb_sel",   64'(bus.ex_wb_sel),   64'(m_ex.wb_sel));
`ifdef ID_EX_PERF_EN
      check("bubble_cnt",  64'(bus.bubble_cnt),  64'(m_bubble));
      check("stall_cnt",   64'(bus.stall_cnt),   64'(m_stall));
`else
      check("bubble_cnt",  64'(bus.bubble_cnt),  64'd0);
      check("stall_cnt",   64'(bus.stall_cnt),   64'd0);
`endif
   endtask

   // Inputs are set at the negedge; the model follows the posedge; outputs are checked at the next negedge.
   task automatic step();
      drive();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      m_ex = '0; m_bubble = 0; m_stall = 0;
      de = '0; en = 0; cl = 0; fl = 0;
      drive();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;

      // Plain load
      de = '0; de.valid = 1; de.pc = 32'h100; de.rd = 5; de.rf_we = 1;
      en = 1; cl = 0; fl = 0;
      step();
      check("load_pc", 64'(bus.ex_pc), 64'h100);

      // Load-use: a load to x3 in execute, dependent instruction stalled in decode
      de = rand_instr(); de.valid = 1; de.dmrd = 1; de.rd = 3;
      step();
      de = rand_instr(); de.valid = 1; de.rs1 = 3;
      en = 0; cl = 1;
      step();
      check("lu_dmrd", 64'(bus.ex_dmrd), 64'd0);
      en = 1; cl = 0;
      step();
      check("lu_rs1", 64'(bus.ex_rs1), 64'd3);

      // Hold three cycles while decode keeps changing
      en = 0; cl = 0; fl = 0;
      for (int i = 0; i < 3; i++) begin
         de = rand_instr();
         step();
      end

      // Flush and clear together count once
      de = rand_instr(); de.valid = 1; de.dmwr = 1;
      en = 1; cl = 1; fl = 1;
      step();

      // Invalid slot loads as a clean bubble
      de = rand_instr(); de.valid = 0; de.dmwr = 1; de.rf_we = 1;
      en = 1; cl = 0; fl = 0;
      step();

      // Randomized control mix
      for (int i = 0; i < 300; i++) begin
         int r;
         r  = int'($urandom_range(0, 9));
         de = rand_instr();
         cl = (r == 0) || (r == 2);
         fl = (r == 1) || (r == 2);
         en = (r >= 5) ? 1'b1 : 1'($urandom);
         step();
      end

      // Mid-cycle asynchronous reset
      de = rand_instr(); de.valid = 1; de.rd = 7;
      en = 1; cl = 0; fl = 0;
      step();
      #2 rst = 1'b1;
      #1 m_ex = '0; m_bubble = 0; m_stall = 0;
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      rst = 1'b0;
      check_all();
      de = rand_instr(); de.valid = 1;
      step();

      // Saturation: 20 consecutive bubbles
      en = 0; cl = 1; fl = 0;
      for (int i = 0; i < 20; i++) begin
         de = rand_instr();
         step();
      end
      en = 0; cl = 0;
      for (int i = 0; i < 18; i++) begin
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
